key_conditioner: RTL and testbench

Input-side conditioner for the board push-buttons: turns a raw, bouncing, asynchronous key level into a synchronized, debounced level plus single-cycle press/release pulses, with optional hold-to-repeat. It sits between the `key*` pins and consumer logic such as counters and mode selects. It is the input end of the key-to-LED path, complementing the LED-driving counter logic.

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_sync.sv | 27 ++
 rtl/key_conditioner.sv | 167 ++++++++++++++++
 tb/tb_key_conditioner.sv | 133 +++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared FSM state type and default timing constants for key_conditioner
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // Intervals in 5 MHz clock cycles
  localparam int unsigned KEY_DEBOUNCE_DEFAULT      = 50000;    // 10 ms
  localparam int unsigned KEY_REPEAT_DELAY_DEFAULT  = 2500000;  // 500 ms
  localparam int unsigned KEY_REPEAT_PERIOD_DEFAULT = 500000;   // 100 ms

  function automatic int unsigned key_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - 2-flop synchronizer with synchronous reset to a chosen level
module key_sync #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounced key level, press/release strobes, auto-repeat under KEY_AUTOREPEAT_EN
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter int unsigned REPEAT_DELAY    = KEY_REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = KEY_REPEAT_PERIOD_DEFAULT
) (
  input  logic clock_5,
  input  logic reset,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             key_synced;
  logic             p;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Reset loads the released pin level so a held key is seen as a fresh edge
  key_sync #(.RESET_VALUE(KEY_ACTIVE_LOW)) u_sync (
    .clk_i (clock_5),
    .rst_i (reset),
    .d_i   (key_in),
    .q_o   (key_synced)
  );

  assign p = KEY_ACTIVE_LOW ? ~key_synced : key_synced;

  // State and debounce counter registers
  always_ff @(posedge clock_5) begin
    if (reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: any opposite sample in a wait state abandons the window
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RELEASED: begin
        cnt_d = '0;
        if (p) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        cnt_d = '0;
        if (!p) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the transition so they line up with the new state
  always_comb begin
    level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    press_d   = (state_q == PRESS_WAIT) && (state_d == PRESSED);
    release_d = (state_q == RELEASE_WAIT) && (state_d == RELEASED);
  end

  // Registered outputs
  always_ff @(posedge clock_5) begin
    if (reset) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = key_max(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RPT_W = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_C  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD_C = RPT_W'(REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;
  logic             rpt_q, rpt_d;

  // Count only while staying in PRESSED; any entry or exit restarts from zero
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_first_d = 1'b1;
    rpt_d       = 1'b0;
    if ((state_q == PRESSED) && (state_d == PRESSED)) begin
      rpt_first_d = rpt_first_q;
      rpt_cnt_d   = rpt_cnt_q + RPT_W'(1);
      if (rpt_cnt_d == (rpt_first_q ? RPT_DELAY_C : RPT_PERIOD_C)) begin
        rpt_d       = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end
    end
  end

  // Repeat counter and strobe registers
  always_ff @(posedge clock_5) begin
    if (reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
      rpt_q       <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
      rpt_q       <= rpt_d;
    end
  end

  assign repeat_pulse = rpt_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed self-checking bench for key_conditioner
module tb_key_conditioner;

  logic clock_5 = 1'b0;
  logic reset;
  logic key_in;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;

  int checks = 0;
  int errors = 0;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  // Expected output vectors: {key_level, press_pulse, release_pulse, repeat_pulse}
  localparam logic [3:0] IDLE  = 4'b0000;
  localparam logic [3:0] HELD  = 4'b1000;
  localparam logic [3:0] PRESS = 4'b1100;
  localparam logic [3:0] REL   = 4'b0010;

  key_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .KEY_ACTIVE_LOW  (1'b1),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clock_5       (clock_5),
    .reset         (reset),
    .key_in        (key_in),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  always #5 clock_5 = ~clock_5;

  task automatic tick();
    @(posedge clock_5);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {key_level, press_pulse, release_pulse, repeat_pulse};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // n edges: idle_exp after each of the first n-1, last_exp after the n-th
  task automatic window(input string tag, input int n, input logic [3:0] idle_exp,
                        input logic [3:0] last_exp);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk($sformatf("%s_e%0d", tag, i), (i == n) ? last_exp : idle_exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    key_in = 1'b1;
    tick(); tick(); tick();
    chk("reset_state", IDLE);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", IDLE);

    // Clean press: pulse and level exactly 7 edges after first pressed sample
    key_in = 1'b0;
    window("clean_press", 7, IDLE, PRESS);

    // Hold: repeats at +10, +13, +16, +19, +22, +25 after press_pulse when enabled
    for (int k = 1; k <= 25; k++) begin
      tick();
      chk($sformatf("hold_p%0d", k),
          {1'b1, 1'b0, 1'b0, RPT_EN && (k >= 10) && (((k - 10) % 3) == 0)});
    end

    // Release with a 2-cycle glitch back to pressed inside the window
    key_in = 1'b1;
    window("rel_start", 3, HELD, HELD);
    key_in = 1'b0;
    window("rel_glitch", 2, HELD, HELD);
    key_in = 1'b1;
    window("rel_final", 7, HELD, REL);
    tick();
    chk("rel_after", IDLE);

    // Bounce on press: 3 low, 1 high, then low held
    key_in = 1'b0;
    window("bounce_low", 3, IDLE, IDLE);
    key_in = 1'b1;
    window("bounce_high", 1, IDLE, IDLE);
    key_in = 1'b0;
    window("bounce_final", 7, IDLE, PRESS);
    tick();
    chk("bounce_after", HELD);

    // Clean release
    key_in = 1'b1;
    window("clean_release", 7, HELD, REL);

    // Reset during PRESS_WAIT with the key held
    key_in = 1'b0;
    window("rst_wait_pre", 4, IDLE, IDLE);
    reset = 1'b1;
    window("rst_wait_in", 2, IDLE, IDLE);
    reset = 1'b0;
    window("rst_wait_post", 7, IDLE, PRESS);
    tick();
    chk("rst_wait_after", HELD);

    // Reset while PRESSED with the key held: cleared, then a fresh press
    reset = 1'b1;
    tick();
    chk("rst_pressed_in", IDLE);
    reset = 1'b0;
    window("rst_pressed_post", 7, IDLE, PRESS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
